// File: rtl/cla_adder_pipe.sv
// Two-stage pipelined carry-lookahead adder/subtractor built from 4-bit groups.
// Stage 1 registers per-bit propagate/generate and per-group P/G of the
// effective operands. Stage 2 resolves group carries with a flattened
// second-level lookahead, then registers sum, carry-out, overflow and the
// block-level propagate/generate flags. A valid/ready handshake with full
// back-pressure buffers at most two beats (one per stage).
// WIDTH must be a multiple of 4 in the range 4..64.
module cla_adder_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             p_all,
  output logic             g_all
);

  localparam int NGRP = WIDTH / 4;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic s1_valid_reg;
  logic s2_valid_reg;
  logic s2_adv;

  // Stage 2 can take a new beat when it is empty or its result is leaving.
  // in_ready never looks at in_valid; reset forces it low.
  assign s2_adv   = !s2_valid_reg | out_ready;
  assign in_ready = rst_n & (!s1_valid_reg | s2_adv);

  // ---------------------------------------------------------------------------
  // Stage 1: effective operands, bit p/g, group P/G
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] beff;
  logic [WIDTH-1:0] p_next;
  logic [WIDTH-1:0] g_next;
  logic [NGRP-1:0]  gp_next;
  logic [NGRP-1:0]  gg_next;
  logic             cin_next;

  // Subtraction is a + ~b + 1, so carry-in is forced high and c_in ignored.
  assign beff     = sub ? ~b : b;
  assign cin_next = sub ? 1'b1 : c_in;
  assign p_next   = a ^ beff;
  assign g_next   = a & beff;

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_s1_grp
    logic [3:0] gp;
    logic [3:0] gg;
    assign gp = p_next[4*gi +: 4];
    assign gg = g_next[4*gi +: 4];
    assign gp_next[gi] = &gp;
    assign gg_next[gi] = gg[3]
                       | (gp[3] & gg[2])
                       | (gp[3] & gp[2] & gg[1])
                       | (gp[3] & gp[2] & gp[1] & gg[0]);
  end

  logic [WIDTH-1:0] s1_p_reg;
  logic [WIDTH-1:0] s1_g_reg;
  logic [NGRP-1:0]  s1_gp_reg;
  logic [NGRP-1:0]  s1_gg_reg;
  logic             s1_cin_reg;

  // Stage 1 occupancy: refills (or empties) whenever the stage can move.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
    end else if (in_ready) begin
      s1_valid_reg <= in_valid;
    end
  end

  // Stage 1 payload: loaded only on an accepted beat, held otherwise.
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) begin
      s1_p_reg   <= p_next;
      s1_g_reg   <= g_next;
      s1_gp_reg  <= gp_next;
      s1_gg_reg  <= gg_next;
      s1_cin_reg <= cin_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: second-level lookahead and in-group carries
  // ---------------------------------------------------------------------------
  logic [NGRP:0]    grp_carry;
  logic [WIDTH-1:0] bit_carry;
  logic             g_all_next;

  // Flattened lookahead: every group carry is a two-level AND/OR of the
  // registered group P/G and the carry-in, with no chaining between groups.
  always_comb begin
    logic acc;
    logic term;
    grp_carry    = '0;
    grp_carry[0] = s1_cin_reg;
    for (int k = 0; k < NGRP; k++) begin
      acc = 1'b0;
      for (int j = 0; j <= k; j++) begin
        term = s1_gg_reg[j];
        for (int m = j + 1; m <= k; m++) begin
          term = term & s1_gp_reg[m];
        end
        acc = acc | term;
      end
      term = s1_cin_reg;
      for (int m = 0; m <= k; m++) begin
        term = term & s1_gp_reg[m];
      end
      grp_carry[k+1] = acc | term;
    end
  end

  // Block generate: carry out of the MSB group assuming a zero carry-in.
  always_comb begin
    logic term;
    g_all_next = 1'b0;
    for (int j = 0; j < NGRP; j++) begin
      term = s1_gg_reg[j];
      for (int m = j + 1; m < NGRP; m++) begin
        term = term & s1_gp_reg[m];
      end
      g_all_next = g_all_next | term;
    end
  end

  for (genvar gi = 0; gi < NGRP; gi++) begin : g_s2_grp
    logic [3:0] gp;
    logic [3:0] gg;
    logic       ci;
    assign gp = s1_p_reg[4*gi +: 4];
    assign gg = s1_g_reg[4*gi +: 4];
    assign ci = grp_carry[gi];
    assign bit_carry[4*gi]   = ci;
    assign bit_carry[4*gi+1] = gg[0] | (gp[0] & ci);
    assign bit_carry[4*gi+2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
    assign bit_carry[4*gi+3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                             | (gp[2] & gp[1] & gp[0] & ci);
  end

  logic [WIDTH-1:0] sum_reg;
  logic             c_out_reg;
  logic             ovf_reg;
  logic             p_all_reg;
  logic             g_all_reg;

  // Stage 2 result register: advances when empty or drained, holds on stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_reg <= 1'b0;
      sum_reg      <= '0;
      c_out_reg    <= 1'b0;
      ovf_reg      <= 1'b0;
      p_all_reg    <= 1'b0;
      g_all_reg    <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        sum_reg   <= s1_p_reg ^ bit_carry;
        c_out_reg <= grp_carry[NGRP];
        ovf_reg   <= bit_carry[WIDTH-1] ^ grp_carry[NGRP];
        p_all_reg <= &s1_gp_reg;
        g_all_reg <= g_all_next;
      end
    end
  end

  assign out_valid = s2_valid_reg;
  assign sum       = sum_reg;
  assign c_out     = c_out_reg;
  assign ovf       = ovf_reg;
  assign p_all     = p_all_reg;
  assign g_all     = g_all_reg;

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: directed vector table and pipeline corner cases
// on a 16-bit instance, plus randomized streams with random stalls on 4, 8,
// 16 and 64-bit instances checked against an arithmetic reference model.
module tb_cla_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int sw_done = 0;

  // Reference model: plain integer arithmetic on the effective operands.
  // Returns {sum[63:0], c_out, ovf, p_all, g_all}.
  function automatic logic [67:0] ref_model(input int w, input logic [63:0] av_in,
                                            input logic [63:0] bv_in, input logic ci,
                                            input logic sb);
    logic [64:0] mask, av, bv, full, half, s;
    logic co, ov, pa, ga, cin;
    mask = (65'd1 << w) - 65'd1;
    av   = {1'b0, av_in} & mask;
    bv   = (sb ? ~{1'b0, bv_in} : {1'b0, bv_in}) & mask;
    cin  = sb ? 1'b1 : ci;
    full = av + bv + {64'd0, cin};
    half = av + bv;
    s    = full & mask;
    co   = full[w];
    ov   = (av[w-1] == bv[w-1]) && (s[w-1] != av[w-1]);
    pa   = ((av ^ bv) & mask) == mask;
    ga   = half[w];
    return {s[63:0], co, ov, pa, ga};
  endfunction

  task automatic chk(input string name, input logic [67:0] act, input logic [67:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // 16-bit instance
  // ---------------------------------------------------------------------------
  logic        rst_n;
  logic        in_valid, in_ready, c_in, sub, out_valid, out_ready;
  logic [15:0] a, b, sum;
  logic        c_out, ovf, p_all, g_all;

  cla_adder_pipe #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf),
    .p_all(p_all), .g_all(g_all)
  );

  typedef struct {
    logic [15:0] a, b;
    logic        c_in, sub;
    logic [15:0] sum;
    logic        c_out, ovf, p_all, g_all;
  } vec_t;

  vec_t        vecs[8];
  logic [67:0] q16[$];
  int          acc16 = 0;
  int          out16 = 0;
  int          cyc16 = 0;
  int          last_pop_cyc = 0;

  function automatic logic [67:0] dut16();
    return {64'(sum), c_out, ovf, p_all, g_all};
  endfunction

  task automatic rand_beat16();
    a    = 16'($urandom);
    b    = 16'($urandom);
    c_in = 1'($urandom);
    sub  = 1'($urandom);
  endtask

  // One cycle: inputs already driven after a falling edge; sample #1 later,
  // score the transfers the next rising edge will perform, move to next fall.
  task automatic step16();
    logic [67:0] exp;
    #1;
    if (out_valid && out_ready) begin
      if (q16.size() == 0) begin
        chk("unexpected_result16", {64'(sum), 4'h0}, 68'h0);
      end else begin
        exp = q16.pop_front();
        chk("result16", dut16(), exp);
        $display("out16 #%0d sum=%h c_out=%b ovf=%b p_all=%b g_all=%b",
                 out16, sum, c_out, ovf, p_all, g_all);
      end
      out16++;
      last_pop_cyc = cyc16;
    end
    if (in_valid && in_ready) begin
      q16.push_back(ref_model(16, 64'(a), 64'(b), c_in, sub));
      acc16++;
    end
    @(negedge clk);
    cyc16++;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    a = v.a; b = v.b; c_in = v.c_in; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("vec_in_ready", 68'(in_ready), 68'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("vec_latency_early", 68'(out_valid), 68'd0);
    @(negedge clk);
    #1;
    chk("vec_out_valid", 68'(out_valid), 68'd1);
    chk("vec_result", dut16(), {64'(v.sum), v.c_out, v.ovf, v.p_all, v.g_all});
    $display("vec %0d a=%h b=%h c_in=%b sub=%b -> sum=%h c_out=%b ovf=%b p_all=%b g_all=%b",
             idx, v.a, v.b, v.c_in, v.sub, sum, c_out, ovf, p_all, g_all);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Sweep instances (4, 8, 64 bit) on their own reset
  // ---------------------------------------------------------------------------
  logic rst_sw_n;
  localparam int NB_SW = 4000;

  initial begin
    rst_sw_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_sw_n = 1'b1;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_sw
    localparam int W = (gi == 0) ? 4 : ((gi == 1) ? 8 : 64);
    logic         w_in_valid, w_in_ready, w_c_in, w_sub, w_out_valid, w_out_ready;
    logic [W-1:0] w_a, w_b, w_sum;
    logic         w_c_out, w_ovf, w_p_all, w_g_all;
    logic [67:0]  q[$];

    cla_adder_pipe #(.WIDTH(W)) dut_sw (
      .clk(clk), .rst_n(rst_sw_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
      .a(w_a), .b(w_b), .c_in(w_c_in), .sub(w_sub), .out_valid(w_out_valid),
      .out_ready(w_out_ready), .sum(w_sum), .c_out(w_c_out), .ovf(w_ovf),
      .p_all(w_p_all), .g_all(w_g_all)
    );

    initial begin
      logic [63:0] rnd;
      logic [67:0] exp;
      int sent, recv, cyc;
      w_in_valid = 1'b0; w_out_ready = 1'b0; w_a = '0; w_b = '0;
      w_c_in = 1'b0; w_sub = 1'b0;
      sent = 0; recv = 0; cyc = 0;
      while (!rst_sw_n) @(negedge clk);
      while (recv < NB_SW && cyc < 20 * NB_SW) begin
        w_in_valid  = (sent < NB_SW) && ($urandom_range(0, 3) != 0);
        w_out_ready = ($urandom_range(0, 3) != 0);
        rnd = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
          0:       w_a = '1;
          1:       w_a = '0;
          default: w_a = rnd[W-1:0];
        endcase
        rnd = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
          0:       w_b = '1;
          1:       w_b = ~w_a;
          default: w_b = rnd[W-1:0];
        endcase
        w_c_in = 1'($urandom);
        w_sub  = 1'($urandom);
        #1;
        if (w_out_valid && w_out_ready) begin
          if (q.size() == 0) begin
            chk("unexpected_result_sweep", {64'(w_sum), 4'h0}, 68'h0);
          end else begin
            exp = q.pop_front();
            chk("result_sweep", {64'(w_sum), w_c_out, w_ovf, w_p_all, w_g_all}, exp);
            $display("sweep w=%0d #%0d sum=%h c_out=%b ovf=%b", W, recv, w_sum, w_c_out, w_ovf);
          end
          recv++;
        end
        if (w_in_valid && w_in_ready) begin
          q.push_back(ref_model(W, 64'(w_a), 64'(w_b), w_c_in, w_sub));
          sent++;
        end
        @(negedge clk);
        cyc++;
      end
      chk("sweep_count", 68'(recv), 68'(NB_SW));
      sw_done++;
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence on the 16-bit instance
  // ---------------------------------------------------------------------------
  initial begin
    int   held_set, stable_err, first_pop, bound;
    logic [67:0] held;

    vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; c_in = 1'b0; sub = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset_in_ready", 68'(in_ready), 68'd0);
    chk("reset_out_valid", 68'(out_valid), 68'd0);
    chk("reset_outputs", dut16(), 68'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", 68'(in_ready), 68'd1);
    @(negedge clk);

    // Directed vectors
    for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);

    // Back-pressure: only two beats fit, outputs hold while stalled
    out_ready = 1'b0; acc16 = 0; out16 = 0; held_set = 0; stable_err = 0; held = '0;
    for (int i = 0; i < 6; i++) begin
      rand_beat16();
      in_valid = 1'b1;
      #1;
      if (out_valid) begin
        if (held_set == 0) begin
          held = dut16(); held_set = 1;
        end else if (dut16() !== held) begin
          stable_err++;
        end
      end
      step16();
    end
    #1;
    chk("stall_accepts", 68'(acc16), 68'd2);
    chk("stall_in_ready", 68'(in_ready), 68'd0);
    chk("stall_out_valid", 68'(out_valid), 68'd1);
    chk("stall_hold", 68'(stable_err), 68'd0);
    chk("stall_no_output", 68'(out16), 68'd0);
    out_ready = 1'b1; first_pop = -1; bound = 0;
    while ((acc16 < 5 || q16.size() != 0) && bound < 30) begin
      in_valid = (acc16 < 5);
      if (in_valid) rand_beat16();
      step16();
      if (out16 == 1 && first_pop < 0) first_pop = last_pop_cyc;
      bound++;
    end
    in_valid = 1'b0;
    chk("drain_count", 68'(out16), 68'd5);
    chk("drain_no_gaps", 68'(last_pop_cyc - first_pop), 68'd4);

    // Reset mid-operation discards in-flight beats
    out_ready = 1'b1; out16 = 0;
    for (int i = 0; i < 2; i++) begin
      rand_beat16(); in_valid = 1'b1;
      step16();
    end
    in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b0;
    #1;
    chk("midreset_in_ready", 68'(in_ready), 68'd0);
    @(negedge clk);
    #1;
    chk("midreset_out_valid", 68'(out_valid), 68'd0);
    chk("midreset_outputs", dut16(), 68'd0);
    rst_n = 1'b1; q16.delete(); out_ready = 1'b1; out16 = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) step16();
    chk("midreset_no_stale", 68'(out16), 68'd0);

    // Randomized 16-bit stream with random stalls
    acc16 = 0; out16 = 0; bound = 0;
    while (out16 < 2000 && bound < 40000) begin
      in_valid  = (acc16 < 2000) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rand_beat16();
      step16();
      bound++;
    end
    in_valid = 1'b0;
    chk("random16_count", 68'(out16), 68'd2000);
    chk("random16_queue_empty", 68'(q16.size()), 68'd0);

    // Wait for the width sweep
    bound = 0;
    while (sw_done < 3 && bound < 90000) begin
      @(negedge clk);
      bound++;
    end
    chk("sweep_done", 68'(sw_done), 68'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
